dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  Parametrised arbiter between NUM_RD_PORTS cache read-refill masters, one write-back master and the single
//  dram_ctrl_sim port. Replaces top-level ad-hoc request muxing: grants one master per burst and steers rd_val/wr_val
//  only to the owner. Holds grant for exactly BLOCK_SIZE words; round-robin among read ports is optional.
// PARAMETERS
//  NUM_RD_PORTS  2   read masters (port 0 = I_Cache, 1 = D_Cache refill); 1..8
//  BLOCK_SIZE    8   words per burst (cache line); power of 2, 2..64
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  WR_PRIORITY   1   1: write beats pending reads in IDLE; 0: write serviced only when no read pending
// PORTS
//  clock         in   1                   system clock, rising edge
//  rst           in   1                   reset; asynchronous, active-high
//  rd_req        in   NUM_RD_PORTS        per-port burst read request; held until burst done
//  rd_addr       in   NUM_RD_PORTS*ADDR_W packed; port k at [k*ADDR_W +: ADDR_W]
//  rd_gnt        out  NUM_RD_PORTS        one-hot owner of current read burst
//  rd_val        out  NUM_RD_PORTS        dram_rd_val routed to owner only
//  rd_data       out  DATA_W              dram_rd_data broadcast
//  wr_req        in   1                   write-back burst request; held until burst done
//  wr_addr       in   ADDR_W              write burst base address
//  wr_data       in   DATA_W              current write word
//  wr_gnt        out  1                   write master owns DRAM
//  wr_val        out  1                   dram_wr_val routed to write master
//  dram_rd_req   out  1                   to controller
//  dram_rd_addr  out  ADDR_W              owner's rd_addr
//  dram_rd_data  in   DATA_W              from controller
//  dram_rd_val   in   1                   one pulse per word read
//  dram_wr_req   out  1                   to controller
//  dram_wr_addr  out  ADDR_W              wr_addr passthrough while granted
//  dram_wr_data  out  DATA_W              wr_data passthrough while granted
//  dram_wr_val   in   1                   one pulse per word written
//  busy          out  1                   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, word counter 0, rr pointer = NUM_RD_PORTS-1, all gnt/req/val/busy 0, addr/data outputs 0.
//  FSM IDLE -> RD_BURST | WR_BURST -> IDLE. Grant, state, dram_*_req are registered; decided only in IDLE.
//  IDLE: arbitrate on sampled rd_req/wr_req; winner's gnt and dram_*_req go high next edge (latency 1 cycle).
//  RD_BURST: count dram_rd_val pulses; at pulse with count==BLOCK_SIZE-1 -> IDLE next edge, req/gnt low, count 0.
//  WR_BURST: same, counting dram_wr_val.
//  Minimum one IDLE cycle between bursts; back-to-back bursts separated by exactly 1 cycle.
//  rd_val[k] = dram_rd_val & rd_gnt[k] & (state==RD_BURST); wr_val = dram_wr_val & wr_gnt. Combinational.
//  Strays: dram_rd_val in IDLE/WR_BURST and dram_wr_val in IDLE/RD_BURST ignored, not counted, not routed.
//  Owner drops req mid-burst: abort, IDLE next edge, count cleared, words already delivered stand.
//  dram_rd_addr/dram_wr_* are muxed from registered grant; 0 when no grant.
//  Counter width clog2(BLOCK_SIZE); never wraps within a burst.
//  Request arriving same cycle burst ends is seen in the following IDLE cycle.
// CONFIGURATION
//  DRAM_ARB_RR_EN defined: read ports round-robin; search from pointer+1 mod NUM_RD_PORTS, pointer <- winner at grant.
//  DRAM_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.
//  WR_PRIORITY applies identically in both builds.
// TESTING (NUM_RD_PORTS=2, BLOCK_SIZE=8)
//  Reset mid-RD_BURST after 3 words -> all outputs 0 asynchronously; next request restarts at count 0.
//  rd_req=2'b01, addr0=0x100, 8 val pulses -> rd_gnt=01 one cycle later, dram_rd_addr=0x100, rd_val[0] x8, rd_val[1]=0, IDLE after 8th.
//  rd_req=2'b11 held for 4 bursts -> RR_EN: grants 0,1,0,1; without RR_EN: 0,0,0,0; 1-cycle gaps.
//  wr_req=1 and rd_req=2'b01 same cycle, WR_PRIORITY=1 -> write burst first (8 wr_val), then read gnt; WR_PRIORITY=0 -> read first.
//  Stray dram_rd_val during WR_BURST -> rd_val stays 0, write count unaffected, burst still ends after 8 wr_val.
//  rd_req[1] dropped after 5 words -> IDLE next edge, rd_gnt=00, count 0, busy=0.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//
// Purpose:
//   Arbitrates between NUM_RD_PORTS cache read-refill masters and a single
//   write-back master for the one dram_ctrl_sim port. A master is granted
//   for a whole burst of BLOCK_SIZE words, and the per-word valid strobes from
//   the controller are steered only to the current owner. Grant, state and
//   dram_*_req are registered and are decided only in IDLE, so every burst
//   is followed by at least one IDLE cycle.
//
// Configuration:
//   DRAM_ARB_RR_EN  defined   : read ports are served round-robin. The search
//                               starts at pointer+1, and the pointer takes the
//                               index of the winner when the grant is made.
//                   undefined : fixed priority, lowest read-port index wins.
//   WR_PRIORITY (parameter)   : 1 = write wins over pending reads in IDLE,
//                               0 = write is serviced only when no read pends.
//
// Ports:
//   clock, rst                  rising-edge clock; asynchronous active-high reset
//   rd_req/rd_addr              per-port burst read requests and base addresses
//   rd_gnt/rd_val/rd_data       owner grant, routed word strobe, broadcast data
//   wr_req/wr_addr/wr_data      write-back burst request, base address, word
//   wr_gnt/wr_val               write owner grant and routed word strobe
//   dram_rd_req/dram_rd_addr    read request/address towards the controller
//   dram_rd_data/dram_rd_val    read data and per-word strobe from controller
//   dram_wr_req/dram_wr_addr/
//   dram_wr_data                write request/address/data towards controller
//   dram_wr_val                 per-word write strobe from controller
//   busy                        a burst is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int NUM_RD_PORTS = 2,
  parameter int BLOCK_SIZE   = 8,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WR_PRIORITY  = 1
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic [NUM_RD_PORTS-1:0]      rd_req,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD_PORTS-1:0]      rd_gnt,
  output logic [NUM_RD_PORTS-1:0]      rd_val,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_gnt,
  output logic                         wr_val,
  output logic                         dram_rd_req,
  output logic [ADDR_W-1:0]            dram_rd_addr,
  input  logic [DATA_W-1:0]            dram_rd_data,
  input  logic                         dram_rd_val,
  output logic                         dram_wr_req,
  output logic [ADDR_W-1:0]            dram_wr_addr,
  output logic [DATA_W-1:0]            dram_wr_data,
  input  logic                         dram_wr_val,
  output logic                         busy
);

  localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_RD_PORTS-1:0] rd_gnt_q, rd_gnt_d;
  logic                    wr_gnt_q, wr_gnt_d;
  logic                    dram_rd_req_q, dram_rd_req_d;
  logic                    dram_wr_req_q, dram_wr_req_d;

  logic [NUM_RD_PORTS-1:0] rd_win;    // one-hot read winner for this IDLE cycle
  logic                    rd_found;
  logic                    any_rd;
  logic                    take_wr;

  assign any_rd = |rd_req;

`ifdef DRAM_ARB_RR_EN
  localparam int PTR_W = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] rd_win_idx;
  logic [PTR_W-1:0] rr_cand;

  // Walk the ports starting just after the last winner; the last candidate
  // visited is the previous winner itself, so a lone requester always wins.
  always_comb begin
    rd_win     = '0;
    rd_found   = 1'b0;
    rd_win_idx = '0;
    rr_cand    = '0;
    for (int i = 1; i <= NUM_RD_PORTS; i++) begin
      rr_cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_RD_PORTS);
      if (!rd_found && rd_req[rr_cand]) begin
        rd_found        = 1'b1;
        rd_win[rr_cand] = 1'b1;
        rd_win_idx      = rr_cand;
      end
    end
  end
`else
  always_comb begin
    rd_win   = '0;
    rd_found = 1'b0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      if (!rd_found && rd_req[i]) begin
        rd_found  = 1'b1;
        rd_win[i] = 1'b1;
      end
    end
  end
`endif

  // Next-state logic. Any exit from a burst (completion or abort) clears the
  // word counter and the grants in the same step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_gnt_d = rd_gnt_q;
    wr_gnt_d = wr_gnt_q;
    take_wr  = 1'b0;
`ifdef DRAM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        take_wr = wr_req && ((WR_PRIORITY != 0) || !any_rd);
        if (take_wr) begin
          state_d  = WR_BURST;
          wr_gnt_d = 1'b1;
        end else if (any_rd) begin
          state_d  = RD_BURST;
          rd_gnt_d = rd_win;
`ifdef DRAM_ARB_RR_EN
          rr_ptr_d = rd_win_idx;
`endif
        end
      end
      RD_BURST: begin
        // Owner withdrew its request: abort, words already delivered stand.
        if ((rd_req & rd_gnt_q) == '0) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rd_gnt_d = '0;
        end else if (dram_rd_val) begin
          if (cnt_q == LAST_WORD) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rd_gnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WR_BURST: begin
        if (!wr_req) begin
          state_d  = IDLE;
          cnt_d    = '0;
          wr_gnt_d = 1'b0;
        end else if (dram_wr_val) begin
          if (cnt_q == LAST_WORD) begin
            state_d  = IDLE;
            cnt_d    = '0;
            wr_gnt_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        rd_gnt_d = '0;
        wr_gnt_d = 1'b0;
      end
    endcase
    dram_rd_req_d = (state_d == RD_BURST);
    dram_wr_req_d = (state_d == WR_BURST);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_gnt_q      <= '0;
      wr_gnt_q      <= 1'b0;
      dram_rd_req_q <= 1'b0;
      dram_wr_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_gnt_q      <= rd_gnt_d;
      wr_gnt_q      <= wr_gnt_d;
      dram_rd_req_q <= dram_rd_req_d;
      dram_wr_req_q <= dram_wr_req_d;
    end
  end

`ifdef DRAM_ARB_RR_EN
  // Starting at the top index makes port 0 the first round-robin winner.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= PTR_W'(NUM_RD_PORTS - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Address mux follows the registered grant; all-zero when nobody owns DRAM.
  always_comb begin
    dram_rd_addr = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      if (rd_gnt_q[k]) begin
        dram_rd_addr = dram_rd_addr | rd_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign dram_wr_addr = wr_gnt_q ? wr_addr : '0;
  assign dram_wr_data = wr_gnt_q ? wr_data : '0;

  // Strobes outside the matching burst state are strays and never routed.
  assign rd_val  = {NUM_RD_PORTS{dram_rd_val && (state_q == RD_BURST)}} & rd_gnt_q;
  assign wr_val  = dram_wr_val && wr_gnt_q && (state_q == WR_BURST);
  assign rd_data = dram_rd_data;

  assign rd_gnt      = rd_gnt_q;
  assign wr_gnt      = wr_gnt_q;
  assign dram_rd_req = dram_rd_req_q;
  assign dram_wr_req = dram_wr_req_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

  localparam int NRD = 2;
  localparam int BS  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WRP = 1;

  logic                clock = 1'b0;
  logic                rst   = 1'b1;
  logic [NRD-1:0]      rd_req;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_gnt;
  logic [NRD-1:0]      rd_val;
  logic [DW-1:0]       rd_data;
  logic                wr_req;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                wr_gnt;
  logic                wr_val;
  logic                dram_rd_req;
  logic [AW-1:0]       dram_rd_addr;
  logic [DW-1:0]       dram_rd_data;
  logic                dram_rd_val;
  logic                dram_wr_req;
  logic [AW-1:0]       dram_wr_addr;
  logic [DW-1:0]       dram_wr_data;
  logic                dram_wr_val;
  logic                busy;

  always #5 clock = ~clock;

  dram_port_arbiter #(
    .NUM_RD_PORTS(NRD), .BLOCK_SIZE(BS), .ADDR_W(AW), .DATA_W(DW), .WR_PRIORITY(WRP)
  ) dut (
    .clock(clock), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_val(rd_val), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_val(wr_val),
    .dram_rd_req(dram_rd_req), .dram_rd_addr(dram_rd_addr), .dram_rd_data(dram_rd_data),
    .dram_rd_val(dram_rd_val), .dram_wr_req(dram_wr_req), .dram_wr_addr(dram_wr_addr),
    .dram_wr_data(dram_wr_data), .dram_wr_val(dram_wr_val), .busy(busy)
  );

  typedef struct {
    bit          is_wr;
    int          port;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [AW-1:0] ADDR0 = 32'h0000_0100;
  localparam logic [AW-1:0] ADDR1 = 32'h0000_0200;
  localparam logic [AW-1:0] WADDR = 32'h0000_0900;

  function automatic exp_t mk(input bit is_wr, input int port);
    exp_t e;
    e.is_wr = is_wr;
    e.port  = port;
    e.addr  = is_wr ? WADDR : ((port == 0) ? ADDR0 : ADDR1);
    return e;
  endfunction

  task automatic do_reset();
    rd_req       = '0;
    wr_req       = 1'b0;
    dram_rd_val  = 1'b0;
    dram_wr_val  = 1'b0;
    dram_rd_data = '0;
    wr_data      = '0;
    exp_q.delete();
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
  endtask

  // Waits for the next grant, pops the expected owner from the scoreboard and
  // delivers nwords strobes, checking routing and that the burst ends exactly
  // after the last one. stray=1 inserts an opposite-direction strobe before
  // every word. Returns at the negedge after the final word (state IDLE).
  task automatic serve_burst(input int nwords, input int exp_wait, input bit stray);
    exp_t           e;
    int             waited;
    logic [NRD-1:0] exp_gnt;
    logic [DW-1:0]  d;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!(dram_rd_req || dram_wr_req) && waited < 20);
    checks++;
    if (!(dram_rd_req || dram_wr_req)) begin
      failures++;
      $display("FAIL grant_timeout got=no_req exp=req after %0d cycles", waited);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_grant got rd_gnt=%b wr_gnt=%b exp=none", rd_gnt, wr_gnt);
      return;
    end
    e = exp_q.pop_front();
    exp_gnt = e.is_wr ? '0 : (NRD'(1) << e.port);
    if (exp_wait >= 0) begin
      checks++;
      if (waited !== exp_wait) begin
        failures++;
        $display("FAIL grant_latency got=%0d exp=%0d", waited, exp_wait);
      end
    end
    checks++;
    if ({wr_gnt, rd_gnt, dram_wr_req, dram_rd_req, busy} !==
        {e.is_wr, exp_gnt, e.is_wr, !e.is_wr, 1'b1}) begin
      failures++;
      $display("FAIL grant got wr_gnt=%b rd_gnt=%b wreq=%b rreq=%b busy=%b exp wr_gnt=%b rd_gnt=%b",
               wr_gnt, rd_gnt, dram_wr_req, dram_rd_req, busy, e.is_wr, exp_gnt);
    end
    checks++;
    if ({dram_wr_addr, dram_rd_addr} !== (e.is_wr ? {e.addr, {AW{1'b0}}} : {{AW{1'b0}}, e.addr})) begin
      failures++;
      $display("FAIL burst_addr got wr=%h rd=%h exp_addr=%h is_wr=%0b",
               dram_wr_addr, dram_rd_addr, e.addr, e.is_wr);
    end
    $display("burst start: %s port=%0d addr=%h", e.is_wr ? "WR" : "RD", e.port, e.addr);
    for (int w = 0; w < nwords; w++) begin
      if (stray) begin
        dram_rd_val = e.is_wr;
        dram_wr_val = !e.is_wr;
        #1;
        checks++;
        if ({rd_val, wr_val, busy} !== {{NRD{1'b0}}, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL stray_route got rd_val=%b wr_val=%b busy=%b exp rd_val=0 wr_val=0 busy=1",
                   rd_val, wr_val, busy);
        end
        @(negedge clock);
      end
      d = DW'($urandom);
      dram_rd_val  = !e.is_wr;
      dram_wr_val  = e.is_wr;
      dram_rd_data = d;
      wr_data      = d;
      #1;
      checks++;
      if ({rd_val, wr_val, busy} !== {(e.is_wr ? {NRD{1'b0}} : exp_gnt), e.is_wr, 1'b1}) begin
        failures++;
        $display("FAIL word_route w=%0d got rd_val=%b wr_val=%b busy=%b exp rd_val=%b wr_val=%b busy=1",
                 w, rd_val, wr_val, busy, exp_gnt, e.is_wr);
      end
      checks++;
      if ((e.is_wr ? dram_wr_data : rd_data) !== d) begin
        failures++;
        $display("FAIL word_data w=%0d got=%h exp=%h", w,
                 e.is_wr ? dram_wr_data : rd_data, d);
      end
      @(negedge clock);
    end
    dram_rd_val = 1'b0;
    dram_wr_val = 1'b0;
    #1;
    checks++;
    if ({busy, rd_gnt, wr_gnt, dram_rd_req, dram_wr_req} !== '0) begin
      failures++;
      $display("FAIL burst_end got busy=%b rd_gnt=%b wr_gnt=%b rreq=%b wreq=%b exp all 0",
               busy, rd_gnt, wr_gnt, dram_rd_req, dram_wr_req);
    end
    $display("burst end: %s port=%0d words=%0d", e.is_wr ? "WR" : "RD", e.port, nwords);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_gnt, wr_gnt, dram_rd_req, dram_wr_req, busy, rd_val, wr_val} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got rd_gnt=%b wr_gnt=%b rreq=%b wreq=%b busy=%b exp all 0",
               rd_gnt, wr_gnt, dram_rd_req, dram_wr_req, busy);
    end
    checks++;
    if ({dram_rd_addr, dram_wr_addr, dram_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_bus got rd_addr=%h wr_addr=%h wr_data=%h exp 0",
               dram_rd_addr, dram_wr_addr, dram_wr_data);
    end
    // Strobes with nobody granted must be neither routed nor start anything.
    dram_rd_val = 1'b1;
    dram_wr_val = 1'b1;
    #1;
    checks++;
    if ({rd_val, wr_val} !== '0) begin
      failures++;
      $display("FAIL idle_stray got rd_val=%b wr_val=%b exp 0", rd_val, wr_val);
    end
    @(negedge clock);
    dram_rd_val = 1'b0;
    dram_wr_val = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_stray_busy got=%b exp=0", busy);
    end
    $display("reset and idle strays checked");
  endtask

  task automatic test_single_read();
    do_reset();
    rd_req = 2'b01;
    exp_q.push_back(mk(1'b0, 0));
    serve_burst(BS, 1, 1'b0);
    rd_req = 2'b00;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_read_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_req = 2'b11;
    for (int b = 0; b < 4; b++) begin
`ifdef DRAM_ARB_RR_EN
      exp_q.push_back(mk(1'b0, b % 2));
`else
      exp_q.push_back(mk(1'b0, 0));
`endif
    end
    for (int b = 0; b < 4; b++) begin
      serve_burst(BS, 1, 1'b0);
    end
    rd_req = 2'b00;
  endtask

  task automatic test_wr_priority();
    do_reset();
    wr_req = 1'b1;
    rd_req = 2'b01;
    if (WRP != 0) begin
      exp_q.push_back(mk(1'b1, 0));
      exp_q.push_back(mk(1'b0, 0));
      serve_burst(BS, 1, 1'b0);
      wr_req = 1'b0;
      serve_burst(BS, 1, 1'b0);
      rd_req = 2'b00;
    end else begin
      exp_q.push_back(mk(1'b0, 0));
      exp_q.push_back(mk(1'b1, 0));
      serve_burst(BS, 1, 1'b0);
      rd_req = 2'b00;
      serve_burst(BS, 1, 1'b0);
      wr_req = 1'b0;
    end
  endtask

  task automatic test_stray();
    do_reset();
    wr_req = 1'b1;
    exp_q.push_back(mk(1'b1, 0));
    serve_burst(BS, 1, 1'b1);
    wr_req = 1'b0;
    rd_req = 2'b10;
    exp_q.push_back(mk(1'b0, 1));
    serve_burst(BS, -1, 1'b1);
    rd_req = 2'b00;
  endtask

  task automatic test_abort();
    int waited;
    do_reset();
    rd_req = 2'b10;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!dram_rd_req && waited < 20);
    checks++;
    if (rd_gnt !== 2'b10) begin
      failures++;
      $display("FAIL abort_grant got=%b exp=10", rd_gnt);
    end
    for (int w = 0; w < 5; w++) begin
      dram_rd_val = 1'b1;
      @(negedge clock);
    end
    dram_rd_val = 1'b0;
    rd_req      = 2'b00;
    @(negedge clock);
    checks++;
    if ({busy, rd_gnt, dram_rd_req} !== '0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b rd_gnt=%b rreq=%b exp all 0", busy, rd_gnt, dram_rd_req);
    end
    $display("abort after 5 words checked");
    // A fresh burst must run a full BS words, proving the count was cleared.
    rd_req = 2'b10;
    exp_q.push_back(mk(1'b0, 1));
    serve_burst(BS, 1, 1'b0);
    rd_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    rd_req = 2'b01;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!dram_rd_req && waited < 20);
    checks++;
    if (rd_gnt !== 2'b01) begin
      failures++;
      $display("FAIL midreset_grant got=%b exp=01", rd_gnt);
    end
    for (int w = 0; w < 3; w++) begin
      dram_rd_val = 1'b1;
      @(negedge clock);
    end
    dram_rd_val = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_gnt, wr_gnt, dram_rd_req, dram_wr_req, busy, dram_rd_addr} !== '0) begin
      failures++;
      $display("FAIL midreset_async got rd_gnt=%b rreq=%b busy=%b rd_addr=%h exp all 0",
               rd_gnt, dram_rd_req, busy, dram_rd_addr);
    end
    @(negedge clock);
    rst = 1'b0;
    $display("asynchronous reset mid-burst checked");
    exp_q.push_back(mk(1'b0, 0));
    serve_burst(BS, 1, 1'b0);
    rd_req = 2'b00;
  endtask

  initial begin
    rd_req       = '0;
    rd_addr      = {ADDR1, ADDR0};
    wr_req       = 1'b0;
    wr_addr      = WADDR;
    wr_data      = '0;
    dram_rd_data = '0;
    dram_rd_val  = 1'b0;
    dram_wr_val  = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wr_priority();
    test_stray();
    test_abort();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
